// File: rtl/board_pixel_fetch_if.sv
// board_pixel_fetch_if: pixel, cell-write, query and ROM-side signals of the playfield fetcher
//   master: VGA/game side drives DrawX/DrawY, write, clear and query; receives ROM drive and status
//   slave : board_pixel_fetch
interface board_pixel_fetch_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       wr_en;
  logic [3:0] wr_col;
  logic [4:0] wr_row;
  logic [2:0] wr_type;
  logic       clear_req;
  logic [3:0] q_col;
  logic [4:0] q_row;
  logic [2:0] q_type;
  logic       busy;
  logic [2:0] blockType;
  logic [9:0] read_address;
  logic       color_valid;
  modport master (
    output DrawX, DrawY, wr_en, wr_col, wr_row, wr_type, clear_req, q_col, q_row,
    input  q_type, busy, blockType, read_address, color_valid
  );
  modport slave (
    input  DrawX, DrawY, wr_en, wr_col, wr_row, wr_type, clear_req, q_col, q_row,
    output q_type, busy, blockType, read_address, color_valid
  );
endinterface

// File: rtl/board_pixel_fetch.sv
// board_pixel_fetch: playfield cell store feeding the BlockColor sprite ROM, with query port and clear engine
//   Clk, Reset_n : clock, asynchronous active-low reset (starts a full board clear)
//   bus (slave)  : DrawX/DrawY in, blockType/read_address/color_valid out (3-cycle aligned),
//                  cell write, cell query (1-cycle), clear_req/busy
module board_pixel_fetch #(
  parameter int unsigned BOARD_X0 = 240,
  parameter int unsigned BOARD_Y0 = 80,
  parameter int unsigned COLS     = 10,
  parameter int unsigned ROWS     = 20
) (
  input logic           Clk,
  input logic           Reset_n,
  board_pixel_fetch_if.slave bus
);
  localparam int unsigned N  = COLS * ROWS;
  localparam int unsigned AW = $clog2(N);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t        state_q;
  logic [AW-1:0] idx_q;
  logic [2:0]    cells [N];
  logic [3:0]    col_s1_q;
  logic [4:0]    row_s1_q;
  logic [7:0]    off_s1_q;
  logic          inb_s1_q;
  logic          vld_s2_q;
  logic [7:0]    dx;
  logic [8:0]    dy;
  logic          in_board;
  logic          wr_ok;
  logic          q_ok;
  logic [AW-1:0] pix_idx;
  logic [AW-1:0] q_idx;
  logic [AW-1:0] wr_idx;
  // Pixels left of / above the origin wrap here; in_board masks them
  assign dx       = 8'(bus.DrawX - 10'(BOARD_X0));
  assign dy       = 9'(bus.DrawY - 10'(BOARD_Y0));
  assign in_board = bus.DrawX >= 10'(BOARD_X0) && bus.DrawX < 10'(BOARD_X0 + COLS * 16) &&
                    bus.DrawY >= 10'(BOARD_Y0) && bus.DrawY < 10'(BOARD_Y0 + ROWS * 16);
  assign pix_idx  = AW'(row_s1_q * COLS + col_s1_q);
  assign q_idx    = AW'(bus.q_row * COLS + bus.q_col);
  assign wr_idx   = AW'(bus.wr_row * COLS + bus.wr_col);
  assign q_ok     = bus.q_col < 4'(COLS) && bus.q_row < 5'(ROWS);
  // A clear request in the same cycle wins over the write
  assign wr_ok    = state_q == IDLE && bus.wr_en && !bus.clear_req &&
                    bus.wr_col < 4'(COLS) && bus.wr_row < 5'(ROWS);
  assign bus.busy = state_q == CLEAR;
  // Cell array has no reset; the clear engine zeroes it after every reset
  always_ff @(posedge Clk) begin
    if (state_q == CLEAR) cells[idx_q] <= '0;
    else if (wr_ok) cells[wr_idx] <= bus.wr_type;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q          <= CLEAR;
      idx_q            <= '0;
      col_s1_q         <= '0;
      row_s1_q         <= '0;
      off_s1_q         <= '0;
      inb_s1_q         <= 1'b0;
      vld_s2_q         <= 1'b0;
      bus.blockType    <= '0;
      bus.read_address <= '0;
      bus.color_valid  <= 1'b0;
      bus.q_type       <= '0;
    end else begin
      if (state_q == IDLE) begin
        if (bus.clear_req) begin
          state_q <= CLEAR;
          idx_q   <= '0;
        end
      end else begin
        idx_q <= idx_q == AW'(N - 1) ? '0 : idx_q + 1'b1;
        if (idx_q == AW'(N - 1)) state_q <= IDLE;
      end
      col_s1_q         <= dx[7:4];
      row_s1_q         <= dy[8:4];
      off_s1_q         <= {dy[3:0], dx[3:0]};
      inb_s1_q         <= in_board;
      bus.blockType    <= inb_s1_q && !bus.busy ? cells[pix_idx] : '0;
      bus.read_address <= {2'b00, off_s1_q};
      vld_s2_q         <= inb_s1_q && !bus.busy;
      bus.color_valid  <= vld_s2_q;
      bus.q_type       <= q_ok && !bus.busy ? cells[q_idx] : '0;
    end
  end
endmodule

// File: tb/tb_board_pixel_fetch.sv
// tb_board_pixel_fetch: directed self-checking bench for board_pixel_fetch
module tb_board_pixel_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n;
  board_pixel_fetch_if bus();
  board_pixel_fetch dut (.Clk(clk), .Reset_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wr(input int c, input int r, input int t);
    bus.wr_col = 4'(c);
    bus.wr_row = 5'(r);
    bus.wr_type = 3'(t);
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask
  task automatic qry(input string tag, input int c, input int r, input int exp);
    bus.q_col = 4'(c);
    bus.q_row = 5'(r);
    @(negedge clk);
    chk(tag, bus.q_type, exp);
  endtask
  task automatic pix(input string tag, input int x, input int y, input int bt, input int ra, input int cv);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    repeat (2) @(negedge clk);
    chk({tag, ".bt"}, bus.blockType, bt);
    chk({tag, ".ra"}, bus.read_address, ra);
    @(negedge clk);
    chk({tag, ".cv"}, bus.color_valid, cv);
  endtask
  // Counts cycles with busy high; pulses wr_en (do_wr) or clear_req at count 'at'
  task automatic count_busy(input int at, input bit do_wr, output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 400) begin
      cnt++;
      bus.wr_en = do_wr && cnt == at;
      bus.clear_req = !do_wr && cnt == at;
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    bus.clear_req = 1'b0;
  endtask
  initial begin
    bus.DrawX = '0; bus.DrawY = '0; bus.wr_en = 0; bus.wr_col = '0; bus.wr_row = '0;
    bus.wr_type = '0; bus.clear_req = 0; bus.q_col = '0; bus.q_row = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.busy", bus.busy, 1);
    chk("rst.bt", bus.blockType, 0);
    chk("rst.ra", bus.read_address, 0);
    chk("rst.cv", bus.color_valid, 0);
    chk("rst.q", bus.q_type, 0);
    rst_n = 1'b1;
    bus.wr_col = 4; bus.wr_row = 4; bus.wr_type = 3;
    count_busy(50, 1'b1, n);
    chk("rst.busy_len", n, 200);
    qry("drop_wr_in_clear", 4, 4, 0);
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) qry("cleared", c, r, 0);
    wr(3, 5, 4);
    pix("p295_169", 295, 169, 4, 151, 1);
    wr(0, 0, 1);
    pix("p240_80", 240, 80, 1, 0, 1);
    wr(9, 19, 6);
    pix("p399_399", 399, 399, 6, 255, 1);
    pix("p239_100", 239, 100, 0, 79, 0);
    pix("p400_100", 400, 100, 0, 64, 0);
    pix("p295_400", 295, 400, 0, 7, 0);
    wr(0, 1, 3);
    wr(10, 0, 2);
    wr(0, 20, 2);
    qry("col10_drop", 0, 1, 3);
    qry("q_col10", 10, 0, 0);
    qry("q_row20", 0, 20, 0);
    qry("row19_keep", 9, 19, 6);
    bus.wr_col = 1; bus.wr_row = 1; bus.wr_type = 7; bus.wr_en = 1; bus.clear_req = 1;
    @(negedge clk);
    bus.wr_en = 0; bus.clear_req = 0;
    count_busy(100, 1'b0, n);
    chk("clr.busy_len", n, 200);
    qry("clr.wr_dropped", 1, 1, 0);
    qry("clr.cell35", 3, 5, 0);
    bus.wr_col = 2; bus.wr_row = 2; bus.wr_type = 5; bus.wr_en = 1;
    bus.q_col = 2; bus.q_row = 2;
    @(negedge clk);
    bus.wr_en = 0;
    chk("rbw.old", bus.q_type, 0);
    @(negedge clk);
    chk("rbw.new", bus.q_type, 5);
    wr(0, 18, 7);
    bus.DrawX = 245; bus.DrawY = 370;
    bus.clear_req = 1;
    @(negedge clk);
    bus.clear_req = 0;
    repeat (100) @(negedge clk);
    chk("mid.busy", bus.busy, 1);
    chk("mid.bt_masked", bus.blockType, 0);
    chk("mid.cv_masked", bus.color_valid, 0);
    chk("mid.ra", bus.read_address, 37);
    #2 rst_n = 1'b0;
    #1;
    chk("async.ra", bus.read_address, 0);
    chk("async.busy", bus.busy, 1);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(-1, 1'b0, n);
    chk("restart.busy_len", n, 200);
    qry("restart.cell180", 0, 18, 0);
    qry("restart.cell22", 2, 2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/board_pixel_fetch.md
Name: board_pixel_fetch

Overview:
- Upstream feeder for the BlockColor sprite ROM in the Tetris display path.
- Holds the 10x20 playfield cell array, written by game logic. Takes VGA DrawX/DrawY, finds the covering cell and the pixel offset inside its 16x16 sprite, and drives blockType/read_address into the ROM.
- Emits a valid flag aligned to the ROM's 1-cycle read latency.
- Also provides a registered cell-query port for collision checks and a self-sequencing board-clear engine.

Parameters:
- BOARD_X0, 240, left pixel column of playfield
- BOARD_Y0, 80, top pixel row of playfield
- COLS, 10, playfield width in cells
- ROWS, 20, playfield height in cells

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- DrawX  in  10  current VGA pixel column
- DrawY  in  10  current VGA pixel row
- wr_en  in  1  cell write strobe
- wr_col  in  4  write column
- wr_row  in  5  write row
- wr_type  in  3  piece type to store (0=empty, 1..7=I,L,J,T,S,Z,O)
- clear_req  in  1  single-cycle request to empty the board
- q_col  in  4  query column
- q_row  in  5  query row
- q_type  out  3  registered cell contents for the query
- busy  out  1  clear engine active
- blockType  out  3  to ROM blockType
- read_address  out  10  to ROM read_address
- color_valid  out  1  ROM data_Out is a board pixel this cycle

Behaviour:
- Cell storage: 200 entries x 3 bits, index = row*10+col. Read-before-write: a same-cycle read of a cell being written returns the old value.
- Stage 1 (registered, +1 cycle):
  - dx = DrawX-BOARD_X0 and dy = DrawY-BOARD_Y0, computed in 10 bits.
  - in_board = (DrawX>=BOARD_X0) && (DrawX<BOARD_X0+160) && (DrawY>=BOARD_Y0) && (DrawY<BOARD_Y0+320).
  - Register col=dx[7:4], row=dy[8:4], offset={dy[3:0],dx[3:0]} and in_board.
- Stage 2 (registered, +2 cycles from DrawX/DrawY):
  - blockType = cell[row*10+col] if in_board_s1 && !busy, else 0.
  - read_address = {2'b00, offset_s1}, i.e. dy[3:0]*16+dx[3:0], range 0..255.
  - vld_s2 = in_board_s1 && !busy.
- Stage 3: color_valid = vld_s2 registered (+3 cycles), aligned with ROM data_Out.
- Outside the board, blockType=0, so the ROM returns FFFFFF and color_valid=0.
- Query port: q_type = cell[q_row*10+q_col], registered, 1-cycle latency. Returns 0 if q_col>=10, q_row>=20 or busy.
- Write port: honoured only when the FSM is in IDLE. Writes with wr_col>=10 or wr_row>=20 are dropped.
- FSM:
  - IDLE: clear_req -> CLEAR with idx=0. A wr_en in the same cycle as clear_req is dropped; clear wins.
  - CLEAR: each cycle writes cell[idx]=0 and increments idx. When idx=199 the write completes and the FSM moves to IDLE. Takes exactly 200 cycles.
  - In CLEAR, busy=1, and wr_en and clear_req are ignored (no restart).
- Reset (Reset_n low, asynchronous):
  - blockType=0, read_address=0, color_valid=0, q_type=0, all pipeline registers 0, idx=0.
  - FSM forced to CLEAR, so busy=1 immediately.
  - On release, the board is cleared in 200 cycles before busy drops. Cell array contents are not async-reset.
  - Reset asserted mid-clear restarts the clear from idx=0.
- Width rules: no wraparound of DrawX/DrawY beyond 10 bits. Values below the origin wrap in dx/dy but are masked by in_board.

Test Plan:
- Reset release -> busy=1 for exactly 200 cycles then 0; q_type=0 for every (col,row). A wr_en at cycle 50 of the clear is dropped (query afterwards returns 0).
- After idle, write (col=3,row=5,type=4); drive DrawX=240+48+7=295, DrawY=80+80+9=169 -> 2 cycles later blockType=4 and read_address=9*16+7=151; 3 cycles later color_valid=1.
- DrawX=239 or 400, DrawY=100 -> blockType=0, color_valid=0 at +2/+3; DrawX=399, DrawY=399 (last board pixel) -> in-board, read_address=255.
- Write (col=10,row=0,type=2) and (col=0,row=20,type=2) -> no cell changes; query q_col=10 returns 0.
- clear_req with wr_en (col=1,row=1,type=7) in the same cycle -> write dropped, busy 200 cycles. A second clear_req at cycle 100 of the clear does not extend it.
- Write cell (2,2)=5 while querying (2,2) in the same cycle -> q_type=old value 0, next-cycle query returns 5. Reset_n pulsed low mid-clear -> outputs 0 asynchronously, clear restarts from idx=0.
